mcp4725_sample_feeder: RTL and testbench

- Upstream stage of the MCP4725 DAC interface. It drives that block's data_i, mode_i and enable inputs.
- Accepts 12-bit samples plus a 2-bit power mode over a valid/ready stream and buffers them in a small FIFO.
- Presents one sample at a time, paced by a programmable cycle period.
- Detects acceptance by watching the DAC block's latched data_reg/mode_reg. Flags underflow and accept timeouts.

---
 rtl/mcp4725_sample_feeder_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/mcp4725_sample_feeder.sv | 156 +++++++++++++++
 tb/tb_mcp4725_sample_feeder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp4725_sample_feeder_pkg.sv
// Shared types and constants for the MCP4725 sample feeder: sample field widths,
// feeder FSM states and the DAC power-down mode encodings.
package mcp4725_sample_feeder_pkg;

  localparam int MCP_DATA_W = 12;
  localparam int MCP_MODE_W = 2;
  localparam int MCP_WORD_W = MCP_DATA_W + MCP_MODE_W;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } feeder_state_t;

  typedef enum logic [MCP_MODE_W-1:0] {
    NORMAL  = 2'd0,
    PD_1K   = 2'd1,
    PD_100K = 2'd2,
    PD_500K = 2'd3
  } mcp_mode_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO. The read-data register only loads on a pop, so it
// doubles as the downstream holding register for the popped word.
module sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_level;
  logic             w_push;
  logic             w_pop;

  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign o_level   = w_level;
  assign o_full    = (w_level == LVL_FULL);
  assign o_empty   = (w_level == '0);
  assign o_rd_data = r_rd_data;

  // A flush discards a same-cycle push, but a same-cycle pop still delivers its word.
  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      end
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/mcp4725_sample_feeder.sv
// Feeds buffered 12-bit samples to the MCP4725 DAC block at a programmable pace,
// detecting acceptance from the DAC's latched data/mode registers.
module mcp4725_sample_feeder
  import mcp4725_sample_feeder_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 200000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [MCP_DATA_W-1:0]   i_s_data,
  input  logic [MCP_MODE_W-1:0]   i_s_mode,
  input  logic                    i_s_valid,
  output logic                    o_s_ready,
  input  logic                    i_run,
  input  logic                    i_flush,
  input  logic [PERIOD_W-1:0]     i_period,
  output logic [MCP_DATA_W-1:0]   o_dac_data,
  output logic [MCP_MODE_W-1:0]   o_dac_mode,
  output logic                    o_dac_enable,
  input  logic [MCP_DATA_W-1:0]   i_dac_data_reg,
  input  logic [MCP_MODE_W-1:0]   i_dac_mode_reg,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_underflow,
  output logic [7:0]              o_underflow_cnt,
  output logic                    o_timeout_err,
  input  logic                    i_clr_status
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  feeder_state_t            r_state;
  feeder_state_t            w_state_next;
  logic [PERIOD_W-1:0]      r_pace_cnt;
  logic [TO_W-1:0]          r_to_cnt;
  logic                     r_issued_once;
  logic                     r_underflow;
  logic [7:0]               r_underflow_cnt;
  logic                     r_timeout_err;

  logic [MCP_WORD_W-1:0]    w_head;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;
  logic                     w_tick;
  logic                     w_accepted;
  logic                     w_uf_event;
  logic                     w_to_event;

  sync_fifo #(
    .WIDTH (MCP_WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (i_s_valid),
    .i_pop     (w_pop),
    .i_flush   (i_flush),
    .i_wr_data ({i_s_mode, i_s_data}),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (o_level)
  );

  assign o_s_ready       = ~w_full;
  assign o_dac_data      = w_head[MCP_DATA_W-1:0];
  assign o_dac_mode      = w_head[MCP_WORD_W-1:MCP_DATA_W];
  assign o_underflow     = r_underflow;
  assign o_underflow_cnt = r_underflow_cnt;
  assign o_timeout_err   = r_timeout_err;

  assign w_tick     = (r_pace_cnt >= i_period);
  assign w_accepted = ({i_dac_mode_reg, i_dac_data_reg} == w_head);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_uf_event   = 1'b0;
    w_to_event   = 1'b0;
    o_dac_enable = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_run && w_tick) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = PRESENT;
          end else if (r_issued_once) begin
            w_uf_event = 1'b1;
          end
        end
      end
      PRESENT: begin
        o_dac_enable = 1'b1;
        // A duplicate of the word the DAC already holds matches on the first cycle.
        if (w_accepted) begin
          w_state_next = IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_to_event   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_pace_cnt      <= '1;
      r_to_cnt        <= '0;
      r_issued_once   <= 1'b0;
      r_underflow     <= 1'b0;
      r_underflow_cnt <= '0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // Restarting on underflow as well limits events to one per period.
      if (w_pop || w_uf_event) begin
        r_pace_cnt <= '0;
      end else if (r_pace_cnt != '1) begin
        r_pace_cnt <= r_pace_cnt + PERIOD_W'(1);
      end

      if (r_state == PRESENT && w_state_next == PRESENT) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end

      if (i_flush) begin
        r_issued_once <= 1'b0;
      end else if (w_pop) begin
        r_issued_once <= 1'b1;
      end

      if (i_clr_status) begin
        r_underflow     <= 1'b0;
        r_underflow_cnt <= '0;
        r_timeout_err   <= 1'b0;
      end else begin
        if (w_uf_event) begin
          r_underflow     <= 1'b1;
          r_underflow_cnt <= sat_inc8(r_underflow_cnt);
        end
        if (w_to_event) begin
          r_timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mcp4725_sample_feeder.sv
// Self-checking bench for mcp4725_sample_feeder with a behavioural DAC model
// and a scoreboard of expected issued samples.
module tb_mcp4725_sample_feeder;

  localparam int DEPTH    = 8;
  localparam int PERIOD_W = 16;
  localparam int TIMEOUT  = 64;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [11:0]         s_data = '0;
  logic [1:0]          s_mode = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic                run = 1'b0;
  logic                flush = 1'b0;
  logic [PERIOD_W-1:0] period = '0;
  logic [11:0]         dac_data;
  logic [1:0]          dac_mode;
  logic                dac_enable;
  logic [11:0]         dac_data_reg;
  logic [1:0]          dac_mode_reg;
  logic [LW-1:0]       level;
  logic                underflow;
  logic [7:0]          underflow_cnt;
  logic                timeout_err;
  logic                clr_status = 1'b0;

  mcp4725_sample_feeder #(
    .DEPTH    (DEPTH),
    .PERIOD_W (PERIOD_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_s_data        (s_data),
    .i_s_mode        (s_mode),
    .i_s_valid       (s_valid),
    .o_s_ready       (s_ready),
    .i_run           (run),
    .i_flush         (flush),
    .i_period        (period),
    .o_dac_data      (dac_data),
    .o_dac_mode      (dac_mode),
    .o_dac_enable    (dac_enable),
    .i_dac_data_reg  (dac_data_reg),
    .i_dac_mode_reg  (dac_mode_reg),
    .o_level         (level),
    .o_underflow     (underflow),
    .o_underflow_cnt (underflow_cnt),
    .o_timeout_err   (timeout_err),
    .i_clr_status    (clr_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DAC model: latches data_i after enable has been high dac_delay-1 cycles,
  // so the feeder sees the match on its dac_delay-th enable cycle.
  int dac_delay = 5;
  bit frozen = 1'b0;
  int acc = 0;
  always @(posedge clk) begin
    if (rst) begin
      dac_data_reg <= '0;
      dac_mode_reg <= '0;
      acc          <= 0;
    end else if (dac_enable && !frozen) begin
      acc <= acc + 1;
      if (acc + 1 == dac_delay - 1) begin
        dac_data_reg <= dac_data;
        dac_mode_reg <= dac_mode;
      end
    end else begin
      acc <= 0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [13:0] sb_q[$];
  int rise_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: each new issue (enable rising) must match the oldest expected sample.
  initial begin
    logic prev_en;
    logic [13:0] exp_word;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (dac_enable && !prev_en) begin
        rise_q.push_back(cyc);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_issue: got 0x%0h with nothing expected (cycle %0d)", {dac_mode, dac_data}, cyc);
        end else begin
          exp_word = sb_q.pop_front();
          check("sb_issue", {18'd0, dac_mode, dac_data}, {18'd0, exp_word});
          $display("issue cycle=%0d data=0x%03h mode=%0d", cyc, dac_data, dac_mode);
        end
      end
      prev_en = dac_enable;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input logic [11:0] d, input logic [1:0] m, input bit store);
    s_valid = 1'b1;
    s_data  = d;
    s_mode  = m;
    if (store) sb_q.push_back({m, d});
    tick();
    s_valid = 1'b0;
  endtask

  task automatic run_len(input logic v, output int n);
    n = 0;
    while (dac_enable == v && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic cleanup();
    int g;
    run = 1'b0;
    g = 0;
    while (dac_enable && g < 200) begin
      g++;
      tick();
    end
    flush      = 1'b1;
    clr_status = 1'b1;
    tick();
    flush      = 1'b0;
    clr_status = 1'b0;
    repeat (120) tick();
  endtask

  typedef struct {
    logic          valid;
    logic          flsh;
    logic [11:0]   data;
    logic          exp_ready;
    logic [LW-1:0] exp_level;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n, n0, m, r4, g, exp_cnt;

    // Full/flush vectors, applied with run=0 so nothing leaves the FIFO.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 1'b0, 12'(16 * i + 1), 1'b1, LW'(i + 1)};
    end
    vecs[8]  = '{1'b1, 1'b0, 12'h0AA, 1'b0, LW'(8)};
    vecs[9]  = '{1'b1, 1'b1, 12'h0BB, 1'b0, LW'(0)};
    vecs[10] = '{1'b1, 1'b0, 12'h0CC, 1'b1, LW'(1)};
    vecs[11] = '{1'b1, 1'b1, 12'h0DD, 1'b1, LW'(0)};
    vecs[12] = '{1'b0, 1'b0, 12'h000, 1'b1, LW'(0)};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_s_ready", s_ready, 1);
    check("rst_level", level, 0);
    check("rst_enable", dac_enable, 0);
    check("rst_dac_data", dac_data, 0);
    check("rst_dac_mode", dac_mode, 0);
    check("rst_underflow", underflow, 0);
    check("rst_uf_cnt", underflow_cnt, 0);
    check("rst_timeout", timeout_err, 0);

    // Full / flush table
    for (int i = 0; i < 13; i++) begin
      s_valid = vecs[i].valid;
      s_data  = vecs[i].data;
      flush   = vecs[i].flsh;
      check($sformatf("tbl%0d_ready", i), s_ready, vecs[i].exp_ready);
      tick();
      check($sformatf("tbl%0d_level", i), level, vecs[i].exp_level);
      $display("vec %0d valid=%0b flush=%0b level=%0d s_ready=%0b", i, vecs[i].valid, vecs[i].flsh, level, s_ready);
    end
    s_valid = 1'b0;
    flush   = 1'b0;

    // Basic issue: period 0, two samples, DAC accepts on the 5th enable cycle
    period    = '0;
    dac_delay = 5;
    run       = 1'b1;
    s_valid = 1'b1; s_data = 12'h123; s_mode = 2'd0; sb_q.push_back({2'd0, 12'h123});
    tick();
    s_data = 12'h456; s_mode = 2'd2; sb_q.push_back({2'd2, 12'h456});
    check("basic_en_n1", dac_enable, 0);
    tick();
    s_valid = 1'b0;
    check("basic_en_n2", dac_enable, 1);
    check("basic_data_n2", dac_data, 12'h123);
    run_len(1'b1, n); check("basic_high1", n, 5);
    run_len(1'b0, n); check("basic_gap", n, 1);
    run_len(1'b1, n); check("basic_high2", n, 5);
    check("basic_level", level, 0);
    cleanup();

    // Pacing: counter restarts from 0 after an issue, so issues are period+1 apart
    period    = 16'd100;
    dac_delay = 10;
    rise_q.delete();
    m = cyc;
    for (int i = 0; i < 4; i++) push(12'h200 + 12'(i), 2'(i), 1'b1);
    run = 1'b1;
    g = 0;
    while (rise_q.size() < 4 && g < 1000) begin
      g++;
      tick();
    end
    check("pace_issues", rise_q.size(), 4);
    if (rise_q.size() == 4) begin
      check("pace_first", rise_q[0], m + 5);
      for (int i = 1; i < 4; i++) check($sformatf("pace_gap%0d", i), rise_q[i] - rise_q[i-1], int'(period) + 1);
    end
    r4 = (rise_q.size() == 4) ? rise_q[3] : cyc;
    wait_until(r4 + 100);
    check("pace_no_uf", underflow, 0);
    tick();
    check("pace_uf_after", underflow, 1);
    cleanup();

    // Underflow: one sample, period 50, events every period+1 cycles once empty
    period    = 16'd50;
    dac_delay = 5;
    m = cyc;
    run = 1'b1;
    push(12'h0AB, 2'd1, 1'b1);
    wait_until(m + 52);
    check("uf_before", underflow, 0);
    check("uf_cnt_before", underflow_cnt, 0);
    tick();
    check("uf_first", underflow, 1);
    check("uf_cnt_first", underflow_cnt, 1);
    wait_until(m + 200);
    exp_cnt = 0;
    for (int j = 1; j < 10; j++) if (1 + (int'(period) + 1) * j < 200) exp_cnt++;
    check("uf_cnt_200", underflow_cnt, exp_cnt);
    check("uf_flag_200", underflow, 1);
    wait_until(m + 1 + (int'(period) + 1) * (exp_cnt + 1));
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("uf_clr_flag", underflow, 0);
    check("uf_clr_cnt", underflow_cnt, 0);
    cleanup();

    // Duplicate: second 0x3FF is accepted on its first PRESENT cycle
    period    = '0;
    dac_delay = 5;
    push(12'h3FF, 2'd3, 1'b1);
    push(12'h3FF, 2'd3, 1'b1);
    run = 1'b1;
    g = 0;
    while (!dac_enable && g < 50) begin
      g++;
      tick();
    end
    run_len(1'b1, n); check("dup_high1", n, 5);
    run_len(1'b0, n); check("dup_gap", n, 1);
    run_len(1'b1, n); check("dup_high2", n, 1);
    cleanup();

    // Timeout: DAC frozen, sample dropped after TIMEOUT PRESENT cycles
    frozen = 1'b1;
    run    = 1'b1;
    push(12'h001, 2'd0, 1'b1);
    tick();
    check("to_enable", dac_enable, 1);
    check("to_err_early", timeout_err, 0);
    run_len(1'b1, n); check("to_high", n, TIMEOUT);
    check("to_err", timeout_err, 1);
    check("to_data_hold", dac_data, 12'h001);
    check("sb_drained", sb_q.size(), 0);
    tick();
    check("to_then_uf", underflow, 1);
    check("to_then_uf_cnt", underflow_cnt, 1);

    // Reset while presenting
    push(12'h5A5, 2'd2, 1'b1);
    push(12'h5A6, 2'd3, 1'b0);
    check("rp_enable", dac_enable, 1);
    rst = 1'b1;
    tick();
    check("rp_enable_off", dac_enable, 0);
    check("rp_level", level, 0);
    check("rp_s_ready", s_ready, 1);
    check("rp_underflow", underflow, 0);
    check("rp_uf_cnt", underflow_cnt, 0);
    check("rp_timeout", timeout_err, 0);
    check("rp_dac_data", dac_data, 0);
    sb_q.delete();
    rst = 1'b0;
    run = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
